// File: rtl/cordiccart2pol_mul_pipe_rs.sv
// Pipelined fixed-point multiplier with valid/ready flow control.
// The product is scaled (shift, optional round, optional clamp) before entering the pipeline.
module cordiccart2pol_mul_pipe_rs #(
    parameter int din0_WIDTH  = 24,
    parameter int din1_WIDTH  = 22,
    parameter int dout_WIDTH  = 24,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int NUM_STAGE   = 3,
    parameter int SHIFT       = 21,
    parameter int ROUND       = 1,
    parameter int SAT         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat
);

    localparam int P  = din0_WIDTH + din1_WIDTH;
    // Two guard bits keep the exact product plus the rounding increment in range.
    localparam int EW = P + 2;
    localparam int CW = ((EW > dout_WIDTH) ? EW : dout_WIDTH) + 2;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    localparam logic [EW-1:0] ONE_E = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] RND_K = ((ROUND != 0) && (SHIFT > 0)) ?
                                      (ONE_E << ((SHIFT > 0) ? SHIFT - 1 : 0)) : {EW{1'b0}};
    localparam logic signed [CW-1:0] MAX_V = RES_SIGNED ?
                                             $signed((ONE_C << (dout_WIDTH - 1)) - ONE_C) :
                                             $signed((ONE_C << dout_WIDTH) - ONE_C);
    localparam logic signed [CW-1:0] MIN_V = RES_SIGNED ?
                                             $signed({CW{1'b0}} - (ONE_C << (dout_WIDTH - 1))) :
                                             $signed({CW{1'b0}});

    logic                   a_ext_s;
    logic                   b_ext_s;
    logic signed [EW-1:0]   a_s;
    logic signed [EW-1:0]   b_s;
    logic signed [EW-1:0]   prod_s;
    logic signed [EW-1:0]   rnd_s;
    logic signed [EW-1:0]   shr_s;
    logic signed [CW-1:0]   ext_s;
    logic [dout_WIDTH-1:0]  res_s;
    logic                   clip_s;
    logic                   en_s;

    logic [NUM_STAGE-1:0]   vld_r;
    logic [NUM_STAGE-1:0]   sat_r;
    logic [dout_WIDTH-1:0]  dat_r [NUM_STAGE];

    assign en_s     = ce & (~out_valid | out_ready);
    assign in_ready = en_s;

    // Extend, multiply, round, shift and clamp the incoming operand pair.
    always_comb begin
        a_ext_s = (DIN0_SIGNED != 0) ? din0[din0_WIDTH-1] : 1'b0;
        b_ext_s = (DIN1_SIGNED != 0) ? din1[din1_WIDTH-1] : 1'b0;
        a_s     = {{(EW-din0_WIDTH){a_ext_s}}, din0};
        b_s     = {{(EW-din1_WIDTH){b_ext_s}}, din1};
        prod_s  = a_s * b_s;
        rnd_s   = prod_s + $signed(RND_K);
        shr_s   = rnd_s >>> SHIFT;
        ext_s   = {{(CW-EW){shr_s[EW-1]}}, shr_s};
        res_s   = ext_s[dout_WIDTH-1:0];
        clip_s  = 1'b0;
        if ((SAT != 0) && (ext_s > MAX_V)) begin
            res_s  = MAX_V[dout_WIDTH-1:0];
            clip_s = 1'b1;
        end else if ((SAT != 0) && (ext_s < MIN_V)) begin
            res_s  = MIN_V[dout_WIDTH-1:0];
            clip_s = 1'b1;
        end else begin
            res_s  = ext_s[dout_WIDTH-1:0];
            clip_s = 1'b0;
        end
    end

    // Pipeline of result/valid/clip registers; all stages advance together on en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_r <= {NUM_STAGE{1'b0}};
            sat_r <= {NUM_STAGE{1'b0}};
            for (int i = 0; i < NUM_STAGE; i++) begin
                dat_r[i] <= {dout_WIDTH{1'b0}};
            end
        end else if (en_s) begin
            vld_r[0] <= in_valid;
            sat_r[0] <= clip_s;
            dat_r[0] <= res_s;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_r[i] <= vld_r[i-1];
                sat_r[i] <= sat_r[i-1];
                dat_r[i] <= dat_r[i-1];
            end
        end
    end

    assign dout      = dat_r[NUM_STAGE-1];
    assign out_valid = vld_r[NUM_STAGE-1];
    assign sat       = sat_r[NUM_STAGE-1];

endmodule

// File: tb/tb_cordiccart2pol_mul_pipe_rs.sv
// Scoreboard bench: default instance (3 stages, round, saturate) plus a
// truncating/wrapping 8-stage instance fed the same accepted operands.
module tb_cordiccart2pol_mul_pipe_rs;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] din0;
    logic [21:0] din1;
    logic        in_ready_m, ov_m, sat_m;
    logic [23:0] dout_m;
    logic        in_valid_a, in_ready_a, ov_a, sat_a;
    logic [23:0] dout_a;

    logic [23:0] xm_d, xa_d;
    logic        xm_s;
    logic [23:0] kv;
    logic        done;

    typedef struct {
        logic [23:0] d;
        logic        s;
        int          t;
    } exp_t;

    exp_t qm[$];
    exp_t qa[$];
    exp_t e;
    int   en_m = 0, en_a = 0;
    int   n_cmp = 0, n_bad = 0;
    logic p_ok = 1'b0, p_ce, p_ovm, p_orm, p_sm, p_ova, p_sa;
    logic [23:0] p_dm, p_da;

    always #5 clk = ~clk;

    assign in_valid_a = in_valid & in_ready_m;

    cordiccart2pol_mul_pipe_rs dut_m (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_ready(in_ready_m), .dout(dout_m),
        .out_valid(ov_m), .out_ready(out_ready), .sat(sat_m)
    );

    cordiccart2pol_mul_pipe_rs #(.NUM_STAGE(8), .ROUND(0), .SAT(0)) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .dout(dout_a),
        .out_valid(ov_a), .out_ready(ce), .sat(sat_a)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Monitor: scoreboard push/pop, latency in enabled cycles, hold-stability checks.
    always @(negedge clk) begin
        if (reset) begin
            p_ok = 1'b0;
        end else begin
            chk("in_ready_m", 64'(in_ready_m), 64'(ce & (~ov_m | out_ready)));
            if (p_ok && (!p_ce || (p_ovm && !p_orm))) begin
                chk("hold_ov_m", 64'(ov_m), 64'(p_ovm));
                chk("hold_dout_m", 64'(dout_m), 64'(p_dm));
                chk("hold_sat_m", 64'(sat_m), 64'(p_sm));
            end
            if (p_ok && !p_ce) begin
                chk("hold_ov_a", 64'(ov_a), 64'(p_ova));
                chk("hold_dout_a", 64'(dout_a), 64'(p_da));
            end
            if (in_valid && in_ready_m) qm.push_back('{xm_d, xm_s, en_m});
            if (in_valid_a && in_ready_a) qa.push_back('{xa_d, 1'b0, en_a});
            if (ov_m && out_ready) begin
                chk("sb_nonempty_m", 64'(qm.size() != 0), 64'd1);
                if (qm.size() != 0) begin
                    e = qm.pop_front();
                    chk("dout_m", 64'(dout_m), 64'(e.d));
                    chk("sat_m", 64'(sat_m), 64'(e.s));
                    chk("latency_m", 64'(en_m - e.t), 64'd3);
                end
            end
            if (ov_a && ce) begin
                chk("sb_nonempty_a", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    chk("dout_a", 64'(dout_a), 64'(e.d));
                    chk("sat_a", 64'(sat_a), 64'd0);
                    chk("latency_a", 64'(en_a - e.t), 64'd8);
                end
            end
            if (ce && (!ov_m || out_ready)) en_m++;
            if (ce) en_a++;
            p_ok  = 1'b1;
            p_ce  = ce;
            p_ovm = ov_m;
            p_orm = out_ready;
            p_dm  = dout_m;
            p_sm  = sat_m;
            p_ova = ov_a;
            p_da  = dout_a;
            p_sa  = sat_a;
        end
    end

    task automatic send(input logic [23:0] a, input logic [21:0] b,
                        input logic [23:0] em, input logic es, input logic [23:0] ea);
        int w;
        din0 = a; din1 = b; xm_d = em; xm_s = es; xa_d = ea;
        in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready_m) break;
            w++;
            if (w > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: waited %0d cycles for in_ready", w);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((qm.size() != 0 || qa.size() != 0) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", 64'(qm.size() + qa.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        din0 = 24'h000000; din1 = 22'h000000; done = 1'b0;
        xm_d = 24'h000000; xm_s = 1'b0; xa_d = 24'h000000; kv = 24'h000000;
        #1;
        chk("rst_ov_m", 64'(ov_m), 64'd0);
        chk("rst_dout_m", 64'(dout_m), 64'd0);
        chk("rst_sat_m", 64'(sat_m), 64'd0);
        chk("rst_ov_a", 64'(ov_a), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // Single isolated transfer, then back-to-back directed vectors.
        send(24'hFFFFFF, 22'h200000, 24'hFFFFFF, 1'b0, 24'hFFFFFF);
        drain();
        send(24'h000003, 22'h100000, 24'h000002, 1'b0, 24'h000001);
        send(24'hFFFFFD, 22'h100000, 24'hFFFFFF, 1'b0, 24'hFFFFFE);
        send(24'h7FFFFF, 22'h3FFFFF, 24'h7FFFFF, 1'b1, 24'hFFFFFA);
        send(24'h800000, 22'h3FFFFF, 24'h800000, 1'b1, 24'h000004);
        send(24'h7FFFFF, 22'h200000, 24'h7FFFFF, 1'b0, 24'h7FFFFF);
        send(24'h000001, 22'h3FFFFF, 24'h000002, 1'b0, 24'h000001);
        send(24'h000001, 22'h100000, 24'h000001, 1'b0, 24'h000000);
        send(24'hFFFFFF, 22'h100000, 24'h000000, 1'b0, 24'hFFFFFF);
        drain();

        // Backpressure: 10-item stream with out_ready low for 5 cycles.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    kv = 24'(i * 1000 - 4000);
                    send(kv, 22'h200000, kv, 1'b0, kv);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // ce toggled every cycle during a stream; consumer follows ce.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    kv = 24'(i * 100 - 250);
                    send(kv, 22'h200000, kv, 1'b0, kv);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    ce = ~ce;
                    out_ready = ce;
                end
                ce = 1'b1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with items in flight.
        send(24'h000011, 22'h200000, 24'h000011, 1'b0, 24'h000011);
        send(24'h000022, 22'h200000, 24'h000022, 1'b0, 24'h000022);
        send(24'h000033, 22'h200000, 24'h000033, 1'b0, 24'h000033);
        #1 reset = 1'b1;
        #1;
        chk("midrst_ov_m", 64'(ov_m), 64'd0);
        chk("midrst_dout_m", 64'(dout_m), 64'd0);
        chk("midrst_sat_m", 64'(sat_m), 64'd0);
        chk("midrst_ov_a", 64'(ov_a), 64'd0);
        chk("midrst_dout_a", 64'(dout_a), 64'd0);
        qm.delete();
        qa.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        send(24'h000007, 22'h200000, 24'h000007, 1'b0, 24'h000007);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
